// File: rtl/ref_mem_seq_if.sv
// Write-port and read-stream bundle for the motion-estimation reference-window memory.
// master = loader/consumer side, slave = memory side.
interface ref_mem_seq_if #(
  parameter int PIXEL = 8,
  parameter int BANKS = 32,
  parameter int AW    = 7,
  parameter int ROWS  = 8
);
  localparam int RSW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [BANKS*PIXEL-1:0]      ref_input;
  logic [BANKS-1:0]            Bank_sel;
  logic [BANKS*AW-1:0]         write_address_all;
  logic                        rd_start;
  logic                        rd_mode;
  logic [AW-1:0]               rd_base;
  logic [RSW-1:0]              rdR_sel;
  logic [AW:0]                 rd_count;
  logic                        rd_ready;
  logic [ROWS*BANKS*PIXEL-1:0] ref_out;
  logic                        out_valid;
  logic                        busy;
  logic                        done;

  modport master (
    output ref_input, Bank_sel, write_address_all,
    output rd_start, rd_mode, rd_base, rdR_sel, rd_count, rd_ready,
    input  ref_out, out_valid, busy, done
  );

  modport slave (
    input  ref_input, Bank_sel, write_address_all,
    input  rd_start, rd_mode, rd_base, rdR_sel, rd_count, rd_ready,
    output ref_out, out_valid, busy, done
  );
endinterface

// File: rtl/ref_mem_seq.sv
// Banked reference-window memory with per-bank write addressing and a burst read sequencer.
// One clock issue-to-valid; output holds while rd_ready is low, reads see pre-write data.
module ref_mem_seq #(
  parameter int PIXEL = 8,
  parameter int BANKS = 32,
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int ROWS  = 8
) (
  input logic          clk,
  input logic          rst_n,
  ref_mem_seq_if.slave bus
);
  localparam int OW = ROWS * BANKS * PIXEL;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state_q, state_d;

  logic [PIXEL-1:0] mem [BANKS][DEPTH];

  logic          mode_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   remaining_q;
  logic [OW-1:0] ref_out_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          done_q;

  logic          start_acc;
  logic          issue;
  logic          flush_ok;
  logic [AW-1:0] start_off;
  logic [AW-1:0] addr_step;
  logic [OW-1:0] rd_data;

  // Memory is deliberately left out of reset so contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (bus.Bank_sel[b])
        mem[b][bus.write_address_all[b*AW +: AW]] <= bus.ref_input[b*PIXEL +: PIXEL];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.rd_start) state_d = (bus.rd_count == '0) ? FLUSH : RUN;
      RUN:     if (issue && remaining_q == (AW+1)'(1)) state_d = FLUSH;
      FLUSH:   if (flush_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_acc = (state_q == IDLE) && bus.rd_start;
    issue     = (state_q == RUN) && (!out_valid_q || bus.rd_ready);
    flush_ok  = (state_q == FLUSH) && (!out_valid_q || bus.rd_ready);
    start_off = bus.rd_mode ? '0 : AW'(bus.rdR_sel);
    addr_step = mode_q ? AW'(ROWS) : AW'(1);
  end

  // Single mode only fills slot 0; the remaining slots read as zero.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int b = 0; b < BANKS; b++) begin
        if (mode_q || r == 0)
          rd_data[(r*BANKS + b)*PIXEL +: PIXEL] = mem[b][addr_q + AW'(r)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      ref_out_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= flush_ok;
      if (start_acc) begin
        mode_q      <= bus.rd_mode;
        addr_q      <= bus.rd_base + start_off;
        remaining_q <= bus.rd_count;
        busy_q      <= 1'b1;
      end
      if (flush_ok) busy_q <= 1'b0;
      if (issue) begin
        ref_out_q   <= rd_data;
        out_valid_q <= 1'b1;
        addr_q      <= addr_q + addr_step;
        remaining_q <= remaining_q - (AW+1)'(1);
      end else if (bus.rd_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ref_out   = ref_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_ref_mem_seq.sv
// Directed bench for ref_mem_seq: table of bursts plus hand sequences for the timing corners.
module tb_ref_mem_seq;
  localparam int PIXEL = 8;
  localparam int BANKS = 32;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int ROWS  = 8;
  localparam int OW    = ROWS * BANKS * PIXEL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ref_mem_seq_if #(.PIXEL(PIXEL), .BANKS(BANKS), .AW(AW), .ROWS(ROWS)) bus ();

  ref_mem_seq #(.PIXEL(PIXEL), .BANKS(BANKS), .DEPTH(DEPTH), .AW(AW), .ROWS(ROWS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [PIXEL-1:0] model [BANKS][DEPTH];

  typedef struct {
    bit mode;
    int base;
    int rsel;
    int count;
    bit bp;
    bit poke;
    int exp_first;
    int exp_step;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int p = 0; p < ROWS*BANKS; p++) begin
        if (act[p*PIXEL +: PIXEL] !== exp[p*PIXEL +: PIXEL]) begin
          $display("FAIL %s: row %0d bank %0d got %h want %h", name, p / BANKS, p % BANKS,
                   act[p*PIXEL +: PIXEL], exp[p*PIXEL +: PIXEL]);
          break;
        end
      end
    end
  endtask

  function automatic logic [OW-1:0] exp_beat(input bit mode, input int first, input int stp, input int i);
    logic [OW-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int b = 0; b < BANKS; b++)
        if (mode || r == 0)
          v[(r*BANKS + b)*PIXEL +: PIXEL] = model[b][(first + i*stp + r) % DEPTH];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cycle(input logic [BANKS-1:0] sel, input int addr, input logic [PIXEL-1:0] val);
    bus.Bank_sel = sel;
    for (int b = 0; b < BANKS; b++) begin
      bus.write_address_all[b*AW +: AW] = AW'(addr);
      bus.ref_input[b*PIXEL +: PIXEL]   = val;
      if (sel[b]) model[b][addr] = val;
    end
    step();
    bus.Bank_sel = '0;
  endtask

  task automatic start(input bit mode, input int base, input int rsel, input int count);
    bus.rd_mode  = mode;
    bus.rd_base  = AW'(base);
    bus.rdR_sel  = 3'(rsel);
    bus.rd_count = (AW+1)'(count);
    bus.rd_start = 1'b1;
    step();
    bus.rd_start = 1'b0;
  endtask

  task automatic run_burst(input vec_t v);
    int n = 0;
    int dc = 0;
    int vc = 0;
    int hold = 0;
    bit held = 0;
    bit fin = 0;
    start(v.mode, v.base, v.rsel, v.count);
    for (int c = 0; c < 80 && !fin; c++) begin
      if (v.poke && c == 0) begin
        bus.rd_start = 1'b1;
        bus.rd_base  = 7'd64;
        bus.rd_count = 8'd5;
        bus.rd_mode  = 1'b0;
      end else begin
        bus.rd_start = 1'b0;
      end
      if (v.bp && bus.out_valid && !held) begin
        hold = 4;
        held = 1;
      end
      bus.rd_ready = (hold == 0);
      if (hold > 0) hold--;
      #1;
      if (!bus.rd_ready) chk("hold_valid", bus.out_valid, 1);
      if (bus.done) dc++;
      if (bus.out_valid) begin
        vc++;
        chk_vec($sformatf("beat%0d_base%0d", n, v.base), bus.ref_out,
                exp_beat(v.mode, v.exp_first, v.exp_step, n));
        if (bus.rd_ready) n++;
      end
      if (bus.done) fin = 1;
      else step();
    end
    bus.rd_start = 1'b0;
    bus.rd_ready = 1'b1;
    chk("transfers", n, v.count);
    chk("done_pulses", dc, 1);
    chk("busy_at_done", bus.busy, 0);
    if (v.count == 0) chk("valid_cycles_zero_count", vc, 0);
    step();
    chk("done_one_cycle", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ref_input = '0;
    bus.Bank_sel = '0;
    bus.write_address_all = '0;
    bus.rd_start = 1'b0;
    bus.rd_mode = 1'b0;
    bus.rd_base = '0;
    bus.rdR_sel = '0;
    bus.rd_count = '0;
    bus.rd_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk_vec("reset_ref_out", bus.ref_out, '0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk_vec("idle_ref_out", bus.ref_out, '0);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);

    for (int k = 0; k < DEPTH; k++) write_cycle('1, k, PIXEL'(k));

    tbl[0] = '{1, 120, 0, 2, 0, 0, 120, 8};
    tbl[1] = '{0,   3, 2, 3, 0, 0,   5, 1};
    tbl[2] = '{1,  16, 0, 3, 1, 0,  16, 8};
    tbl[3] = '{1,   0, 0, 0, 0, 0,   0, 0};
    tbl[4] = '{0, 127, 3, 2, 0, 0,   2, 1};
    tbl[5] = '{1, 124, 0, 1, 0, 0, 124, 8};
    tbl[6] = '{1,   0, 0, 2, 0, 1,   0, 8};
    tbl[7] = '{1,  40, 5, 1, 0, 0,  40, 8};
    for (int i = 0; i < 8; i++) run_burst(tbl[i]);

    // Zero-length burst: done lands on the second cycle after start.
    start(1, 0, 0, 0);
    chk("zero_c1_done", bus.done, 0);
    chk("zero_c1_busy", bus.busy, 1);
    step();
    chk("zero_c2_done", bus.done, 1);
    chk("zero_c2_busy", bus.busy, 0);
    chk("zero_c2_valid", bus.out_valid, 0);
    step();

    // Skewed per-bank writes, then single-row reads of rows 1 and 2.
    write_cycle(32'h0000000F, 1, 8'h55);
    write_cycle(32'h000000F0, 2, 8'h33);
    run_burst('{0, 1, 0, 2, 0, 0, 1, 1});
    chk("skew_model_b0", model[0][1], 8'h55);
    chk("skew_model_b4", model[4][1], 8'h01);

    // Collision: row 5 written on the same edge it is issued.
    start(0, 5, 0, 1);
    bus.Bank_sel = '1;
    for (int b = 0; b < BANKS; b++) begin
      bus.write_address_all[b*AW +: AW] = 7'd5;
      bus.ref_input[b*PIXEL +: PIXEL]   = 8'h0F;
    end
    step();
    bus.Bank_sel = '0;
    chk("collision_valid", bus.out_valid, 1);
    chk("collision_old_b0", bus.ref_out[7:0], 8'h05);
    chk("collision_old_b31", bus.ref_out[31*PIXEL +: PIXEL], 8'h05);
    chk("collision_slot1_zero", bus.ref_out[BANKS*PIXEL +: PIXEL], 0);
    step();
    chk("collision_done", bus.done, 1);
    step();
    for (int b = 0; b < BANKS; b++) model[b][5] = 8'h0F;
    run_burst('{0, 5, 0, 1, 0, 0, 5, 1});

    // Reset in the middle of a burst.
    bus.rd_ready = 1'b0;
    start(1, 0, 0, 4);
    step();
    chk("pre_reset_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_vec("midreset_ref_out", bus.ref_out, '0);
    chk("midreset_valid", bus.out_valid, 0);
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_done", bus.done, 0);
    bus.rd_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_burst('{1, 32, 0, 1, 0, 0, 32, 8});
    run_burst('{1, 0, 0, 1, 0, 0, 0, 8});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ref_mem_seq.md
Name: ref_mem_seq

Overview:
- Parametrised reference-window memory for the HEVC integer motion-estimation array.
- BANKS pixel columns, each with independent write addressing, so the loader can write skewed or diagonal patterns.
- An internal read sequencer streams either ROWS consecutive rows per beat (multi mode) or one selected row per beat (single mode) to the PE array, with a valid/ready handshake and a done pulse.
- Successor to the fixed 32-bank, 8-row reference memory; adds generic sizing, sequenced bursts, backpressure and a defined collision order.

Parameters:
- PIXEL, 8, bits per pixel
- BANKS, 32, pixel columns (banks) per row
- DEPTH, 128, rows per bank; power of two
- AW, 7, address width, log2(DEPTH)
- ROWS, 8, rows returned per beat in multi mode; must divide DEPTH

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ref_input  in  BANKS*PIXEL  write row data; bank b uses bits [b*PIXEL +: PIXEL]
- Bank_sel  in  BANKS  per-bank write enable
- write_address_all  in  BANKS*AW  per-bank write address; bank b uses [b*AW +: AW]
- rd_start  in  1  start-burst pulse
- rd_mode  in  1  0 = single row, 1 = ROWS rows; sampled at start
- rd_base  in  AW  first row address; sampled at start
- rdR_sel  in  log2(ROWS)  row offset added in single mode; sampled at start
- rd_count  in  AW+1  beats in burst; sampled at start
- rd_ready  in  1  consumer ready
- ref_out  out  ROWS*BANKS*PIXEL  row r occupies [r*BANKS*PIXEL +: BANKS*PIXEL]
- out_valid  out  1  ref_out valid
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end

Behaviour:
- Reset: ref_out=0, out_valid=0, busy=0, done=0, FSM=IDLE, counters 0. Memory array is not reset; contents are undefined until written.
- Write path:
  - Each cycle, every bank b with Bank_sel[b]=1 stores its pixel at its own address.
  - Writes proceed in every FSM state.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - When rd_start=1: latch mode, beat address addr = rd_base (+rdR_sel in single mode, mod DEPTH), remaining = rd_count; busy=1.
  - Next state is RUN, or FLUSH if rd_count=0.
- RUN, beat issue:
  - A beat issues when (!out_valid || rd_ready).
  - Multi mode: output row r = memory row (addr+r) mod DEPTH, r = 0..ROWS-1.
  - Single mode: slot 0 = row addr; slots 1..ROWS-1 = 0.
- RUN, output register:
  - Data is registered; out_valid=1 the cycle after issue. Latency is one clock from issue to valid.
  - When out_valid=1 and rd_ready=0, ref_out and out_valid hold.
  - When out_valid=1, rd_ready=1 and no new beat issues, out_valid drops next cycle.
- RUN, address step: after each issue, addr += ROWS (multi) or 1 (single), wrapping mod DEPTH, and remaining -= 1.
- RUN exit: when remaining reaches 0, go to FLUSH.
- FLUSH: wait until out_valid=0, or until out_valid=1 with rd_ready=1. Then assert done for one cycle, clear busy, go to IDLE.
- rd_count=0: no beats; done pulses the second cycle after start.
- rd_start while busy: ignored, no effect.
- Read/write collision in the same cycle and same bank/address: the read returns old data (read-before-write).
- Reset asserted mid-burst: all outputs and FSM return to reset values immediately; memory keeps its contents.

Test Plan:
- Reset/idle: hold rst_n=0 → ref_out=0, out_valid=0, busy=0, done=0. Release, no start → outputs stay 0.
- Multi burst, wrap-around:
  - Write row k with pixel value k in all banks (k=0..127).
  - Start rd_mode=1, rd_base=120, rd_count=2, rd_ready=1.
  - Beat 1 rows = 120..127; beat 2 rows = 0..7 (wrap).
  - Then done pulses once, busy falls.
- Single mode with offset: rd_mode=0, rd_base=3, rdR_sel=2, rd_count=3 → slot 0 = rows 5, 6, 7 on consecutive cycles; other slots 0.
- Backpressure: multi burst, rd_count=3; hold rd_ready=0 for 4 cycles after the first valid → ref_out stable with out_valid=1. No beat lost or duplicated after release; done after third transfer.
- Skewed write and collision:
  - Write 8'h55 with Bank_sel=32'h0000000F to address 1, and 8'h33 with Bank_sel=32'h000000F0 to address 2; read single rows 1 and 2 → only those banks carry the data.
  - Write 8'h0F to row 5 in the same cycle row 5 is issued → old value returned; re-read returns 8'h0F.
- Control corners:
  - rd_count=0 → done with no out_valid.
  - rd_start during busy → ignored.
  - Reset mid-burst → outputs 0 at once; a new burst after reset reads the previously written data.
